// File: rtl/bbc_mem_pkg.sv
// Shared constants and types for the BBC memory-side loader path.
//
// Contents:
//   ADDR_W         SDRAM byte address width
//   BASE_IDX0      SDRAM base of download index 0 (OS/MOS/sideways ROM image)
//   BASE_IDXN      SDRAM base of every non-zero download index
//   loader_state_e loader FSM states {IDLE, LOAD, DRAIN}
package bbc_mem_pkg;

   localparam int ADDR_W = 25;

   localparam logic [ADDR_W-1:0] BASE_IDX0 = 25'h080000;
   localparam logic [ADDR_W-1:0] BASE_IDXN = 25'h068000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } loader_state_e;

endpackage

// File: rtl/rom_download_stager_sync_fifo.sv
// Small synchronous FIFO with a combinational head (first-word fall-through).
//
// Ports:
//   clk_i     clock
//   reset_i   synchronous active-high reset; empties the FIFO
//   push_i    write din_i; ignored when full unless pop_i pops in the same cycle
//   pop_i     drop the head entry; ignored when empty
//   din_i     write data
//   dout_o    head entry, valid while empty_o = 0
//   full_o    DEPTH entries held
//   empty_o   no entries held
//
// Handshake: a push takes effect when push_i=1 and (full_o=0 or an accepted
// pop happens in the same cycle); a pop takes effect when pop_i=1 and
// empty_o=0. A simultaneous push and pop leaves occupancy unchanged.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == DEPTH_C);
   assign do_pop  = pop_i & ~empty_o;
   // The pop frees a slot in the same cycle, so a full FIFO can still take a push.
   assign do_push = push_i & (~full_o | do_pop);
   assign dout_o  = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally.
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
         else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/rom_download_stager.sv
// Stages data_io ROM download bytes into the SDRAM loader port.
//
// Bytes strobed by ioctl_wr are mapped to their SDRAM ROM region (chosen by
// the download index latched when ioctl_download rises), queued, and replayed
// one per mem_sync slot. loader_active covers the download plus the drain of
// any bytes still queued, so core reset spans the whole upload.
//
// Ports:
//   clk_32m         system clock
//   reset           synchronous active-high reset
//   ioctl_download  data_io download in progress
//   ioctl_index     download index (menu slot)
//   ioctl_wr        byte strobe, one cycle per byte
//   ioctl_addr      byte offset within the download
//   ioctl_dout      byte data
//   mem_sync        SDRAM slot boundary pulse, one cycle wide
//   loader_active   download or drain in progress
//   loader_we       SDRAM write request, constant for a whole slot
//   loader_addr     SDRAM byte address of the slot's write
//   loader_data     SDRAM write data of the slot's write
//   overflow        sticky: a byte was dropped because the FIFO was full
//   byte_count      bytes committed in the current download
//
// Handshake: none towards data_io (no back-pressure). Towards SDRAM, the
// write for a slot is presented from the cycle after one mem_sync until the
// next mem_sync, where it is considered committed.
module rom_download_stager #(
   parameter int DEPTH = 8,
   parameter int ADDR_W = bbc_mem_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0] BASE_IDX0 = bbc_mem_pkg::BASE_IDX0,
   parameter logic [ADDR_W-1:0] BASE_IDXN = bbc_mem_pkg::BASE_IDXN
) (
   input  logic              clk_32m,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic              mem_sync,
   output logic              loader_active,
   output logic              loader_we,
   output logic [ADDR_W-1:0] loader_addr,
   output logic [7:0]        loader_data,
   output logic              overflow,
   output logic [ADDR_W-1:0] byte_count
);

   import bbc_mem_pkg::*;

   localparam int FW = ADDR_W + 8;
   localparam logic [ADDR_W-1:0] CNT_ONE = 1;

   loader_state_e     state_q, state_d;
   logic              dl_q;
   logic [7:0]        idx_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        data_q;
   logic              ovf_q, ovf_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   logic              dl_rise;
   logic [7:0]        idx_eff;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] push_addr;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic [FW-1:0]     fifo_head;
   logic              drop;
   logic              start_clear;
   logic              commit;

   assign dl_rise = ioctl_download & ~dl_q;
   // A byte in the very cycle of the download rise must already see the new index.
   assign idx_eff = dl_rise ? ioctl_index : idx_q;
   assign base = (idx_eff == 8'd0) ? BASE_IDX0 : BASE_IDXN;
   // ADDR_W-bit sum: wraps, carry discarded.
   assign push_addr = base + ioctl_addr;

   assign fifo_pop = mem_sync & ~fifo_empty;
   assign drop = ioctl_wr & fifo_full & ~fifo_pop;
   // Each mem_sync closes the current slot; a slot that carried a write commits it.
   assign commit = mem_sync & we_q;

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_32m),
      .reset_i (reset),
      .push_i  (ioctl_wr),
      .pop_i   (fifo_pop),
      .din_i   ({push_addr, ioctl_dout}),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // FSM: state register
   always_ff @(posedge clk_32m) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM: next state. Leaving DRAIN needs a mem_sync with the FIFO empty,
   // i.e. the boundary where loader_we is about to be (or stay) 0.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (dl_rise) state_d = LOAD;
         LOAD:    if (!ioctl_download) state_d = DRAIN;
         DRAIN: begin
            if (dl_rise)                      state_d = LOAD;
            else if (mem_sync && fifo_empty)  state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      loader_active = (state_q != IDLE);
      // A re-rise from DRAIN continues the same upload, so counters carry on.
      start_clear   = (state_q == IDLE) & dl_rise;
   end

   always_comb begin
      ovf_d = (start_clear ? 1'b0 : ovf_q) | drop;
      cnt_d = start_clear ? '0 : cnt_q;
      if (commit && !start_clear) cnt_d = cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk_32m) begin
      if (reset) begin
         dl_q   <= 1'b0;
         idx_q  <= 8'd0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= 8'd0;
         ovf_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         dl_q  <= ioctl_download;
         ovf_q <= ovf_d;
         cnt_q <= cnt_d;
         if (dl_rise) idx_q <= ioctl_index;
         // Slot register: only updated on slot boundaries, so loader_we and
         // the write it describes stay constant for the whole slot.
         if (mem_sync) begin
            we_q <= ~fifo_empty;
            if (!fifo_empty) begin
               addr_q <= fifo_head[FW-1:8];
               data_q <= fifo_head[7:0];
            end
         end
      end
   end

   assign loader_we   = we_q;
   assign loader_addr = addr_q;
   assign loader_data = data_q;
   assign overflow    = ovf_q;
   assign byte_count  = cnt_q;

endmodule

// File: tb/tb_rom_download_stager.sv
module tb_rom_download_stager;

   logic        clk_32m = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = 8'd0;
   wire         mem_sync;
   logic        loader_active;
   logic        loader_we;
   logic [24:0] loader_addr;
   logic [7:0]  loader_data;
   logic        overflow;
   logic [24:0] byte_count;

   logic gen_sync = 1'b0;
   logic manual_sync = 1'b0;
   bit   sync_en = 1'b0;
   bit   check_len = 1'b0;
   assign mem_sync = gen_sync | manual_sync;

   int checks = 0;
   int errors = 0;
   int wr_seen = 0;
   logic [32:0] exp_q[$];

   rom_download_stager dut (
      .clk_32m        (clk_32m),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .mem_sync       (mem_sync),
      .loader_active  (loader_active),
      .loader_we      (loader_we),
      .loader_addr    (loader_addr),
      .loader_data    (loader_data),
      .overflow       (overflow),
      .byte_count     (byte_count)
   );

   // ---------------- clock / slot generator ----------------
   always #5 clk_32m = ~clk_32m;

   initial begin
      int phase;
      phase = 0;
      forever begin
         @(posedge clk_32m);
         #1;
         gen_sync = sync_en && (phase == 7);
         phase = (phase + 1) % 8;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   logic ms_q = 1'b0;
   logic rst_q = 1'b1;
   always @(posedge clk_32m) begin
      ms_q  <= mem_sync;
      rst_q <= reset;
   end

   logic prev_we = 1'b0;
   int   run_len = 0;
   int   run_wr = 0;
   always @(negedge clk_32m) begin
      logic [32:0] e;
      if (!rst_q && ms_q && loader_we) begin
         wr_seen++;
         run_wr++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h data=%h, required no write", loader_addr, loader_data);
         end else begin
            e = exp_q.pop_front();
            if ({loader_addr, loader_data} !== e) begin
               errors++;
               $display("FAIL slot_write: addr=%h data=%h, required addr=%h data=%h",
                        loader_addr, loader_data, e[32:8], e[7:0]);
            end
         end
      end else if (!rst_q && !ms_q) begin
         checks++;
         if (loader_we !== prev_we) begin
            errors++;
            $display("FAIL we_stable_in_slot: loader_we=%b, required %b", loader_we, prev_we);
         end
      end
      if (loader_we) run_len++;
      else if (prev_we) begin
         if (check_len) begin
            checks++;
            if (run_len != 8 * run_wr) begin
               errors++;
               $display("FAIL we_slot_length: %0d cycles, required %0d", run_len, 8 * run_wr);
            end
         end
         run_len = 0;
         run_wr = 0;
      end
      prev_we = loader_we;
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk_32m);
      #1;
   endtask

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic write_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_wr = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      cyc();
      ioctl_wr = 1'b0;
   endtask

   // Waits until loader_active drops; reports whether loader_we was high on
   // the cycle before (active fell at the boundary that closed a write slot).
   task automatic wait_drain(input int max, output bit fell_with_close);
      bit   done;
      logic pw;
      done = 1'b0;
      fell_with_close = 1'b0;
      pw = loader_we;
      for (int i = 0; i < max && !done; i++) begin
         @(negedge clk_32m);
         if (!loader_active) begin
            done = 1'b1;
            fell_with_close = pw;
         end
         pw = loader_we;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout: loader_active still 1 after %0d cycles, required 0", max);
      end
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [7:0]  idx;
      logic [7:0]  idx_mid;
      logic [24:0] addr;
      logic [7:0]  data;
      logic [24:0] exp_addr;
   } vec_t;

   vec_t vecs[6];

   initial begin
      bit fwc;
      int base_wr;

      vecs[0] = '{idx: 8'd1,   idx_mid: 8'd1,   addr: 25'h0003FFF, data: 8'h55, exp_addr: 25'h006BFFF};
      vecs[1] = '{idx: 8'd0,   idx_mid: 8'd5,   addr: 25'h0000010, data: 8'h12, exp_addr: 25'h0080010};
      vecs[2] = '{idx: 8'd7,   idx_mid: 8'd0,   addr: 25'h0000000, data: 8'h34, exp_addr: 25'h0068000};
      vecs[3] = '{idx: 8'hFF,  idx_mid: 8'hFF,  addr: 25'h0017FFF, data: 8'h56, exp_addr: 25'h007FFFF};
      vecs[4] = '{idx: 8'd0,   idx_mid: 8'd0,   addr: 25'h1FFFFFF, data: 8'h78, exp_addr: 25'h007FFFF};
      vecs[5] = '{idx: 8'd2,   idx_mid: 8'd2,   addr: 25'h1F98000, data: 8'h9A, exp_addr: 25'h0000000};

      // ---- reset ----
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      chk("reset_active",  {32'd0, loader_active}, 33'd0);
      chk("reset_we",      {32'd0, loader_we}, 33'd0);
      chk("reset_addr",    {8'd0, loader_addr}, 33'd0);
      chk("reset_data",    {25'd0, loader_data}, 33'd0);
      chk("reset_ovf",     {32'd0, overflow}, 33'd0);
      chk("reset_count",   {8'd0, byte_count}, 33'd0);
      sync_en = 1'b1;

      // ---- two bytes, index 0, slot length / commit / active fall ----
      check_len = 1'b1;
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      cyc();
      chk("t1_active_on", {32'd0, loader_active}, 33'd1);
      exp_q.push_back({25'h0080000, 8'hA9});
      exp_q.push_back({25'h0080001, 8'h4C});
      write_byte(25'h0000000, 8'hA9);
      write_byte(25'h0000001, 8'h4C);
      ioctl_download = 1'b0;
      cyc();
      wait_drain(100, fwc);
      chk("t1_active_fall_at_close", {32'd0, fwc}, 33'd1);
      chk("t1_we_low", {32'd0, loader_we}, 33'd0);
      chk("t1_count", {8'd0, byte_count}, 33'd2);
      chk("t1_queue_empty", 33'(exp_q.size()), 33'd0);
      check_len = 1'b0;

      // ---- address mapping table ----
      for (int i = 0; i < 6; i++) begin
         ioctl_index = vecs[i].idx;
         ioctl_download = 1'b1;
         cyc();
         ioctl_index = vecs[i].idx_mid;
         exp_q.push_back({vecs[i].exp_addr, vecs[i].data});
         write_byte(vecs[i].addr, vecs[i].data);
         ioctl_download = 1'b0;
         cyc();
         wait_drain(100, fwc);
         chk("map_count", {8'd0, byte_count}, 33'd1);
         chk("map_queue_empty", 33'(exp_q.size()), 33'd0);
      end

      // ---- overflow: 9 writes with no slots ----
      sync_en = 1'b0;
      repeat (10) cyc();
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      cyc();
      for (int i = 0; i < 9; i++) begin
         if (i < 8) exp_q.push_back({25'h0080000 + 25'(i), 8'hC0 + 8'(i)});
         write_byte(25'(i), 8'hC0 + 8'(i));
      end
      chk("ovf_set", {32'd0, overflow}, 33'd1);
      ioctl_download = 1'b0;
      sync_en = 1'b1;
      cyc();
      wait_drain(200, fwc);
      chk("ovf_count", {8'd0, byte_count}, 33'd8);
      chk("ovf_queue_empty", 33'(exp_q.size()), 33'd0);
      chk("ovf_sticky", {32'd0, overflow}, 33'd1);

      // ---- full FIFO: push and mem_sync in the same cycle ----
      sync_en = 1'b0;
      repeat (10) cyc();
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      cyc();
      chk("ovf_cleared_on_start", {32'd0, overflow}, 33'd0);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({25'h0080100 + 25'(i), 8'h20 + 8'(i)});
         write_byte(25'h100 + 25'(i), 8'h20 + 8'(i));
      end
      chk("full_no_ovf", {32'd0, overflow}, 33'd0);
      exp_q.push_back({25'h0080108, 8'h28});
      ioctl_wr = 1'b1;
      ioctl_addr = 25'h108;
      ioctl_dout = 8'h28;
      manual_sync = 1'b1;
      cyc();
      manual_sync = 1'b0;
      ioctl_wr = 1'b0;
      chk("full_pushpop_no_ovf", {32'd0, overflow}, 33'd0);
      chk("full_pushpop_we", {32'd0, loader_we}, 33'd1);
      // Occupancy must still be 8, so the next lone write is dropped.
      write_byte(25'h109, 8'h29);
      chk("full_still_full", {32'd0, overflow}, 33'd1);
      ioctl_download = 1'b0;
      sync_en = 1'b1;
      cyc();
      wait_drain(200, fwc);
      chk("full_count", {8'd0, byte_count}, 33'd9);
      chk("full_queue_empty", 33'(exp_q.size()), 33'd0);

      // ---- download falls with 3 bytes queued ----
      sync_en = 1'b0;
      repeat (10) cyc();
      ioctl_index = 8'd3;
      ioctl_download = 1'b1;
      cyc();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back({25'h0068200 + 25'(i), 8'h60 + 8'(i)});
         write_byte(25'h200 + 25'(i), 8'h60 + 8'(i));
      end
      ioctl_download = 1'b0;
      cyc();
      chk("drain_active_held", {32'd0, loader_active}, 33'd1);
      base_wr = wr_seen;
      sync_en = 1'b1;
      wait_drain(200, fwc);
      chk("drain_writes", 33'(wr_seen - base_wr), 33'd3);
      chk("drain_active_fall_at_close", {32'd0, fwc}, 33'd1);
      chk("drain_we_low", {32'd0, loader_we}, 33'd0);
      chk("drain_count", {8'd0, byte_count}, 33'd3);

      // ---- reset mid-upload ----
      sync_en = 1'b0;
      repeat (10) cyc();
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      cyc();
      exp_q.push_back({25'h0080300, 8'h70});
      write_byte(25'h300, 8'h70);
      write_byte(25'h301, 8'h71);
      write_byte(25'h302, 8'h72);
      manual_sync = 1'b1;
      cyc();
      manual_sync = 1'b0;
      chk("rst_pre_we", {32'd0, loader_we}, 33'd1);
      reset = 1'b1;
      ioctl_download = 1'b0;
      cyc();
      chk("rst_we_drop", {32'd0, loader_we}, 33'd0);
      chk("rst_active_drop", {32'd0, loader_active}, 33'd0);
      chk("rst_count", {8'd0, byte_count}, 33'd0);
      reset = 1'b0;
      base_wr = wr_seen;
      sync_en = 1'b1;
      repeat (40) cyc();
      chk("rst_no_writes", 33'(wr_seen - base_wr), 33'd0);
      chk("rst_we_idle", {32'd0, loader_we}, 33'd0);
      chk("rst_queue_empty", 33'(exp_q.size()), 33'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
